// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I size codes, FSM states
// and the alignment rule.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  // Illegal funct3 codes report as aligned; they are flagged separately.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_H, F3_HU: mis = addr_lo[0];
      F3_W:        mis = (addr_lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic: merges store data into the old word and extracts and
// extends load data for the addressed byte/halfword/word.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        err_size
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = old_word[{addr_lo, 3'b000} +: 8];
  assign half_sel = old_word[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_data = 32'h0;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h0, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0, half_sel};
      F3_W:    load_data = old_word;
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    store_word = old_word;
    case (funct3)
      F3_B:    store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    store_word = wdata;
      default: store_word = old_word;
    endcase
  end

  // Unsigned size codes only make sense for loads.
  always_comb begin
    case (funct3)
      F3_B, F3_H, F3_W: err_size = 1'b0;
      F3_BU, F3_HU:     err_size = we;
      default:          err_size = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding RV32I load/store, fixed
// latency from acceptance to response, error flag for bad size/alignment/range.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [31:0] mem [DEPTH];

  dmem_state_t state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_funct3;
  logic [AW-1:0] idx;
  logic [31:0] old_word;
  logic [31:0] store_word;
  logic [31:0] load_data;
  logic        err_size;
  logic        out_of_range;
  logic        acc_err;
  logic        enter_resp;
  logic        mem_wr;
  logic [31:0] rdata_d;

  // In IDLE the live request drives the access so LATENCY==1 can hit on the accept edge.
  assign cur_we     = (state_q == IDLE) ? req_we     : we_q;
  assign cur_addr   = (state_q == IDLE) ? req_addr   : addr_q;
  assign cur_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;
  assign cur_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;

  assign idx      = cur_addr[AW+1:2];
  assign old_word = mem[idx];

  dmem_lane_unit u_lane (
    .funct3     (cur_funct3),
    .addr_lo    (cur_addr[1:0]),
    .we         (cur_we),
    .old_word   (old_word),
    .wdata      (cur_wdata),
    .store_word (store_word),
    .load_data  (load_data),
    .err_size   (err_size)
  );

  assign out_of_range = (32'(cur_addr[31:2]) >= DEPTH);
  assign acc_err      = err_size | is_misaligned(cur_funct3, cur_addr[1:0]) | out_of_range;

  assign enter_resp = ((state_q == IDLE) && req_valid && req_ready && (LATENCY == 1)) ||
                      ((state_q == WAIT) && (cnt_q == 4'd0));
  assign mem_wr     = enter_resp && cur_we && !acc_err && !srst;
  assign rdata_d    = (!cur_we && !acc_err) ? load_data : 32'h0;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      mem[idx] <= store_word;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            funct3_q  <= req_funct3;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state_q    <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rdata_d;
              resp_err   <= acc_err;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q    <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rdata_d;
            resp_err   <= acc_err;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q    <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
